// File: rtl/adder_operand_seq_pkg.sv
// Shared types and constants for the adder operand sequencer: FSM states,
// beat indices and the bit layout of the packed 33-bit operand word.
package adder_operand_seq_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam logic [2:0] BEAT_X   = 3'd0;
  localparam logic [2:0] BEAT_Y   = 3'd1;
  localparam logic [2:0] BEAT_Z   = 3'd2;
  localparam logic [2:0] BEAT_W   = 3'd3;
  localparam logic [2:0] BEAT_CIN = 3'd4;

  localparam int X_LSB   = 0;
  localparam int Y_LSB   = 8;
  localparam int Z_LSB   = 16;
  localparam int W_LSB   = 24;
  localparam int CIN_BIT = 32;
  localparam int PACK_W  = 33;

  // Field order matches the offsets above: cin at bit 32, x at [7:0].
  typedef struct packed {
    logic       cin;
    logic [7:0] w;
    logic [7:0] z;
    logic [7:0] y;
    logic [7:0] x;
  } operand_t;

endpackage

// File: rtl/adder_operand_seq_if.sv
// Requester-side streams of the operand sequencer: byte-serial operand input
// and the result return channel, both valid/ready.
interface adder_operand_seq_if #(
  parameter int SUM_W = 10
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             in_abort;
  logic             res_valid;
  logic [SUM_W-1:0] res_data;
  logic             res_zero;
  logic             res_ready;

  modport master (
    output in_valid, in_data, in_abort, res_ready,
    input  in_ready, res_valid, res_data, res_zero
  );

  modport slave (
    input  in_valid, in_data, in_abort, res_ready,
    output in_ready, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/adder_operand_seq.sv
// Collects x,y,z,w,cin bytes, drives the packed word to the adder and returns its result after RES_LAT+1 cycles.
// Input is stalled (in_ready=0) from the last beat until the result handshake; the result holds while res_ready is low.
module adder_operand_seq
  import adder_operand_seq_pkg::*;
#(
  parameter int RES_LAT = 1,
  parameter int SUM_W   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_operand_seq_if.slave  bus,
  output operand_t            ins,
  output logic                ins_valid,
  input  logic [SUM_W-1:0]    sm_r,
  input  logic                sm_zero_r,
  output logic                cin_err
);

  localparam logic [2:0] LAT = 3'(RES_LAT);

  state_t     state;
  logic [2:0] beat;
  logic [2:0] wait_cnt;
  logic [7:0] sh_x, sh_y, sh_z, sh_w;

  // Ready is forced low while reset is asserted even though state already reads COLLECT.
  assign bus.in_ready = rst_n & (state == COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      beat          <= BEAT_X;
      wait_cnt      <= 3'd0;
      sh_x          <= 8'd0;
      sh_y          <= 8'd0;
      sh_z          <= 8'd0;
      sh_w          <= 8'd0;
      ins           <= '0;
      ins_valid     <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_zero  <= 1'b0;
      cin_err       <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.in_abort) begin
            beat <= BEAT_X;
          end else if (bus.in_valid) begin
            case (beat)
              BEAT_X: begin sh_x <= bus.in_data; beat <= beat + 3'd1; end
              BEAT_Y: begin sh_y <= bus.in_data; beat <= beat + 3'd1; end
              BEAT_Z: begin sh_z <= bus.in_data; beat <= beat + 3'd1; end
              BEAT_W: begin sh_w <= bus.in_data; beat <= beat + 3'd1; end
              BEAT_CIN: begin
                // The whole word lands at once so the adder never sees a partial set.
                ins       <= '{cin: bus.in_data[0], w: sh_w, z: sh_z, y: sh_y, x: sh_x};
                ins_valid <= 1'b1;
                wait_cnt  <= LAT;
                beat      <= BEAT_X;
                state     <= ISSUE;
                if (|bus.in_data[7:1]) cin_err <= 1'b1;
              end
              default: beat <= BEAT_X;
            endcase
          end
        end
        ISSUE: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            bus.res_data  <= sm_r;
            bus.res_zero  <= sm_zero_r;
            bus.res_valid <= 1'b1;
            state         <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_operand_seq.sv
// Directed bench: two sequencers (RES_LAT=1 and RES_LAT=2) each paired with an
// adder model of matching register depth; expected sums are hand-computed.
module tb_adder_operand_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  adder_operand_seq_if #(.SUM_W(10)) b1 ();
  adder_operand_seq_if #(.SUM_W(10)) b2 ();

  logic [32:0] ins1, ins2;
  logic        iv1, iv2, ce1, ce2;
  logic [9:0]  sm1, sm2, st2;
  logic        zr1, zr2, stz2;

  adder_operand_seq #(.RES_LAT(1), .SUM_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .ins(ins1), .ins_valid(iv1),
    .sm_r(sm1), .sm_zero_r(zr1), .cin_err(ce1)
  );

  adder_operand_seq #(.RES_LAT(2), .SUM_W(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .ins(ins2), .ins_valid(iv2),
    .sm_r(sm2), .sm_zero_r(zr2), .cin_err(ce2)
  );

  // Adder: x + y[3:2] + z + w + cin, registered.
  function automatic logic [9:0] add_f(input logic [32:0] v);
    return 10'(v[7:0]) + 10'(v[11:10]) + 10'(v[23:16]) + 10'(v[31:24]) + 10'(v[32]);
  endfunction

  always_ff @(posedge clk) begin
    sm1  <= add_f(ins1);
    zr1  <= (add_f(ins1) == 10'd0);
    st2  <= add_f(ins2);
    stz2 <= (add_f(ins2) == 10'd0);
    sm2  <= st2;
    zr2  <= stz2;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic a);
    if (sel == 1) begin
      b1.in_valid = v; b1.in_data = d; b1.in_abort = a;
    end else begin
      b2.in_valid = v; b2.in_data = d; b2.in_abort = a;
    end
  endtask

  // Entered and left at a negedge; five back-to-back beats.
  task automatic send_set(input int sel, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4);
    logic [7:0] bs [5];
    bs[0] = a0; bs[1] = a1; bs[2] = a2; bs[3] = a3; bs[4] = a4;
    for (int i = 0; i < 5; i++) begin
      drive(sel, 1'b1, bs[i], 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_res(input int sel, output int n, output int pulses);
    n = 0;
    pulses = (sel == 1) ? int'(iv1) : int'(iv2);
    while (((sel == 1) ? b1.res_valid : b2.res_valid) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      pulses += (sel == 1) ? int'(iv1) : int'(iv2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, p;
    logic stable, rose;

    rst_n = 1'b0;
    drive(1, 1'b0, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 1'b0);
    b1.res_ready = 1'b1;
    b2.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(b1.in_ready), 64'd0);
    check("rst_ins", 64'(ins1), 64'd0);
    check("rst_ins_valid", 64'(iv1), 64'd0);
    check("rst_res_valid", 64'(b1.res_valid), 64'd0);
    check("rst_res_data", 64'(b1.res_data), 64'd0);
    check("rst_cin_err", 64'(ce1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(b1.in_ready), 64'd1);

    // Basic sum: 16 + 3 + 32 + 48 + 1 = 100
    send_set(1, 8'h10, 8'h0C, 8'h20, 8'h30, 8'h01);
    check("basic_ins", 64'(ins1), 64'h130200C10);
    check("basic_ins_valid", 64'(iv1), 64'd1);
    check("basic_in_ready_issue", 64'(b1.in_ready), 64'd0);
    wait_res(1, n, p);
    check("basic_latency", 64'(n), 64'd2);
    check("basic_ins_valid_pulses", 64'(p), 64'd1);
    check("basic_res_data", 64'(b1.res_data), 64'd100);
    check("basic_res_zero", 64'(b1.res_zero), 64'd0);
    @(negedge clk);
    check("basic_res_valid_drop", 64'(b1.res_valid), 64'd0);
    check("basic_in_ready_back", 64'(b1.in_ready), 64'd1);
    check("basic_ins_held", 64'(ins1), 64'h130200C10);

    // Zero result
    send_set(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_res(1, n, p);
    check("zero_res_data", 64'(b1.res_data), 64'd0);
    check("zero_res_zero", 64'(b1.res_zero), 64'd1);
    @(negedge clk);

    // Max: 255 + 3 + 255 + 255 + 1 = 769
    send_set(1, 8'hFF, 8'h0C, 8'hFF, 8'hFF, 8'h01);
    wait_res(1, n, p);
    check("max_res_data", 64'(b1.res_data), 64'd769);
    check("max_res_zero", 64'(b1.res_zero), 64'd0);
    @(negedge clk);

    // Back-pressure: 1 + 1 + 2 + 3 + 0 = 7, stray byte offered during stall
    b1.res_ready = 1'b0;
    send_set(1, 8'h01, 8'h04, 8'h02, 8'h03, 8'h00);
    wait_res(1, n, p);
    check("bp_latency", 64'(n), 64'd2);
    stable = 1'b1;
    drive(1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b1.res_valid !== 1'b1 || b1.res_data !== 10'd7 || b1.in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    drive(1, 1'b0, 8'h00, 1'b0);
    b1.res_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 64'(b1.res_valid), 64'd0);
    // 2 + 2 + 3 + 4 + 0 = 11; beat alignment proves no stray byte was taken
    send_set(1, 8'h02, 8'h08, 8'h03, 8'h04, 8'h00);
    wait_res(1, n, p);
    check("bp_next_res", 64'(b1.res_data), 64'd11);
    @(negedge clk);

    // Abort on beat 2, then fresh set: 10 + 2 + 20 + 30 + 1 = 63
    drive(1, 1'b1, 8'h05, 1'b0); @(posedge clk); @(negedge clk);
    drive(1, 1'b1, 8'h04, 1'b0); @(posedge clk); @(negedge clk);
    drive(1, 1'b1, 8'h77, 1'b1); @(posedge clk); @(negedge clk);
    drive(1, 1'b0, 8'h00, 1'b0);
    check("abort_no_issue", 64'(b1.in_ready), 64'd1);
    send_set(1, 8'h0A, 8'h08, 8'h14, 8'h1E, 8'h01);
    check("abort_ins", 64'(ins1), 64'h11E14080A);
    wait_res(1, n, p);
    check("abort_res", 64'(b1.res_data), 64'd63);
    @(negedge clk);

    // cin byte 0x03: error flag set, cin=1 used: 1 + 0 + 1 + 1 + 1 = 4
    check("cin_err_clear", 64'(ce1), 64'd0);
    send_set(1, 8'h01, 8'h00, 8'h01, 8'h01, 8'h03);
    check("cin_ins", 64'(ins1), 64'h101010001);
    check("cin_err_set", 64'(ce1), 64'd1);
    wait_res(1, n, p);
    check("cin_res", 64'(b1.res_data), 64'd4);
    @(negedge clk);
    send_set(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    wait_res(1, n, p);
    check("cin_clean_res", 64'(b1.res_data), 64'd1);
    check("cin_err_sticky", 64'(ce1), 64'd1);
    @(negedge clk);

    // Reset during ISSUE
    send_set(1, 8'h10, 8'h0C, 8'h20, 8'h30, 8'h01);
    rst_n = 1'b0;
    #1;
    check("midrst_ins", 64'(ins1), 64'd0);
    check("midrst_cin_err", 64'(ce1), 64'd0);
    check("midrst_in_ready", 64'(b1.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b1.res_valid !== 1'b0) rose = 1'b1;
    end
    check("midrst_no_result", 64'(rose), 64'd0);
    check("midrst_collect", 64'(b1.in_ready), 64'd1);

    // RES_LAT=2 with a 2-deep adder
    send_set(2, 8'h10, 8'h0C, 8'h20, 8'h30, 8'h01);
    check("lat2_ins", 64'(ins2), 64'h130200C10);
    wait_res(2, n, p);
    check("lat2_latency", 64'(n), 64'd3);
    check("lat2_res_data", 64'(b2.res_data), 64'd100);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
